// File: rtl/core_if_pkg.sv
`default_nettype none
// ============================================================================
// Package  : core_if_pkg
// Brief    : Shared types, bus widths and helpers for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package core_if_pkg;

    localparam int          c_inst_addr_w = 32;
    localparam int          c_inst_w      = 32;
    localparam logic [31:0] c_inst_step   = 32'd4;
    localparam logic [31:0] c_zero_word   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    function automatic logic [c_inst_addr_w-1:0] word_align(input logic [c_inst_addr_w-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : core_if_fifo
// Brief    : First-word-fall-through FIFO with synchronous clear and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module core_if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    typedef logic [c_ptr_w-1:0] ptr_t;
    typedef logic [c_cnt_w-1:0] cnt_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    ptr_t             r_wr_ptr;
    ptr_t             r_rd_ptr;
    cnt_t             r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != cnt_t'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_count <= r_count + cnt_t'(w_do_push) - cnt_t'(w_do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/core_if.sv
`default_nettype none
// ============================================================================
// Module   : core_if
// Brief    : Instruction-fetch stage: PC ownership, credit-limited imem fetch,
//            buffered FWFT delivery to IF/ID and redirect flushing.
// Revision : 1.0 - initial release
// ============================================================================
module core_if
    import core_if_pkg::*;
#(
    parameter logic [c_inst_addr_w-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                       FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid_out,
    output logic [c_inst_addr_w-1:0] imem_req_addr_out,
    input  logic                     imem_req_ready_in,
    input  logic                     imem_resp_valid_in,
    input  logic [c_inst_w-1:0]      imem_resp_data_in,
    output logic                     inst_valid_out,
    output logic [c_inst_w-1:0]      inst_out,
    output logic [c_inst_addr_w-1:0] inst_addr_out,
    input  logic                     id_ready_in,
    input  logic                     jump_en_in,
    input  logic [c_inst_addr_w-1:0] jump_addr_in,
    output logic                     proto_err_out
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    typedef logic [c_cnt_w-1:0] cnt_t;
    localparam cnt_t c_depth = cnt_t'(FIFO_DEPTH);

    if_state_e                r_state;
    if_state_e                w_state_nxt;
    logic [c_inst_addr_w-1:0] r_pc;
    logic [c_inst_addr_w-1:0] w_pc_nxt;
    cnt_t                     r_drop;
    cnt_t                     w_drop_nxt;
    logic                     r_proto_err;

    cnt_t                     w_outstanding;
    cnt_t                     w_ib_count;
    cnt_t                     w_out_after;
    logic [c_cnt_w:0]         w_credit_used;
    logic                     w_req_valid;
    logic                     w_req_accept;
    logic                     w_resp_ok;
    logic                     w_resp_orphan;
    logic                     w_ib_push;
    logic                     w_ib_pop;
    logic                     w_inst_valid;
    logic [2*c_inst_w-1:0]    w_ib_head;
    logic [c_inst_addr_w-1:0] w_aq_head;

    // The address queue occupancy is the outstanding-request count.
    core_if_fifo #(
        .WIDTH (c_inst_addr_w),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_q (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_req_accept),
        .i_push_data (r_pc),
        .i_pop       (w_resp_ok),
        .i_clear     (1'b0),
        .o_count     (w_outstanding),
        .o_head      (w_aq_head)
    );

    core_if_fifo #(
        .WIDTH (2 * c_inst_w),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_ib_push),
        .i_push_data ({imem_resp_data_in, w_aq_head}),
        .i_pop       (w_ib_pop),
        .i_clear     (jump_en_in),
        .o_count     (w_ib_count),
        .o_head      (w_ib_head)
    );

    assign w_credit_used = {1'b0, w_outstanding} + {1'b0, w_ib_count};
    assign w_req_valid   = (r_state == IF_FETCH) && (w_credit_used < {1'b0, c_depth}) && !jump_en_in;
    assign w_req_accept  = w_req_valid && imem_req_ready_in;
    assign w_resp_ok     = imem_resp_valid_in && (w_outstanding != '0);
    assign w_resp_orphan = imem_resp_valid_in && (w_outstanding == '0);
    assign w_out_after   = w_outstanding + cnt_t'(w_req_accept) - cnt_t'(w_resp_ok);
    assign w_ib_push     = w_resp_ok && (r_state == IF_FETCH) && (r_drop == '0) && !jump_en_in;
    assign w_inst_valid  = (w_ib_count != '0);
    assign w_ib_pop      = w_inst_valid && id_ready_in && !jump_en_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IF_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_proto_err <= r_proto_err | w_resp_orphan;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        if (jump_en_in) begin
            // Every request still in flight after this edge belongs to the old path.
            w_pc_nxt    = word_align(jump_addr_in);
            w_drop_nxt  = w_out_after;
            w_state_nxt = (w_out_after != '0) ? IF_DRAIN : IF_FETCH;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    w_state_nxt = IF_FETCH;
                end
                IF_FETCH: begin
                    if (w_req_accept) begin
                        w_pc_nxt = r_pc + c_inst_step;
                    end
                end
                IF_DRAIN: begin
                    if (w_resp_ok && (r_drop != '0)) begin
                        w_drop_nxt = r_drop - cnt_t'(1);
                    end
                    if (w_drop_nxt == '0) begin
                        w_state_nxt = IF_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = IF_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid_out = w_req_valid;
    assign imem_req_addr_out  = r_pc;
    assign inst_valid_out     = w_inst_valid;
    assign inst_out           = w_inst_valid ? w_ib_head[2*c_inst_w-1:c_inst_w] : c_zero_word;
    assign inst_addr_out      = w_inst_valid ? w_ib_head[c_inst_addr_w-1:0] : c_zero_word;
    assign proto_err_out      = r_proto_err;

endmodule
`default_nettype wire
